// File: rtl/gamestats_pkg.sv
// Shared types and constants for the GameStats display path.
package gamestats_pkg;

  typedef logic [3:0] bcd_t;

  localparam int DIGIT_W_DEF = 16;
  localparam int DIGIT_H_DEF = 32;
  localparam int PIXEL_W     = 11;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_CONVERT,
    CV_DONE
  } cv_state_t;

endpackage

// File: rtl/score_digit_driver_if.sv
// Game-side value handshake plus scan-side pixel request/response bundle.
interface score_digit_driver_if #(
  parameter int VALUE_W = 14
);
  import gamestats_pkg::*;

  logic [VALUE_W-1:0] value;
  logic               load;
  logic               startOfFrame;
  logic [PIXEL_W-1:0] pixelX;
  logic [PIXEL_W-1:0] pixelY;
  bcd_t               digit;
  logic [PIXEL_W-1:0] offsetX;
  logic [PIXEL_W-1:0] offsetY;
  logic               insideRectangle;
  logic               busy;
  logic               overflow;

  modport master (
    output value, load, startOfFrame, pixelX, pixelY,
    input  digit, offsetX, offsetY, insideRectangle, busy, overflow
  );

  modport slave (
    input  value, load, startOfFrame, pixelX, pixelY,
    output digit, offsetX, offsetY, insideRectangle, busy, overflow
  );

endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per clock, VALUE_W steps.
module bin2bcd_serial
  import gamestats_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      value,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  cv_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [VALUE_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_busy;
  logic              r_done;
  logic [BCD_W-1:0]  w_adj;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_adj = dabble_adjust(r_bcd);

  // A start seen in DONE chains straight into the next conversion.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= CV_IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CV_IDLE, CV_DONE: begin
          if (start) begin
            r_state <= CV_CONVERT;
            r_bin   <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= CV_IDLE;
            r_busy  <= 1'b0;
          end
        end
        CV_CONVERT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(VALUE_W - 1)) begin
            r_state <= CV_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= CV_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/score_digit_driver.sv
// Binary value to on-screen decimal digits: clamps, converts, buffers per frame,
// and maps each scan pixel onto a glyph cell for the number renderer.
module score_digit_driver
  import gamestats_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 14,
  parameter int DIGIT_W       = DIGIT_W_DEF,
  parameter int DIGIT_H       = DIGIT_H_DEF,
  parameter int TOP_LEFT_X    = 0,
  parameter int TOP_LEFT_Y    = 0,
  parameter int BLANK_LEADING = 1
) (
  input logic                 clk,
  input logic                 resetN,
  score_digit_driver_if.slave bus
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int LOG_W = $clog2(DIGIT_W);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(10**NUM_DIGITS - 1);
  localparam logic signed [11:0] ROW_W = 12'(NUM_DIGITS * DIGIT_W);
  localparam logic signed [11:0] ROW_H = 12'(DIGIT_H);
  localparam logic signed [11:0] ORG_X = 12'(TOP_LEFT_X);
  localparam logic signed [11:0] ORG_Y = 12'(TOP_LEFT_Y);

  function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  logic               w_busy;
  logic               w_done;
  logic               w_start;
  logic [BCD_W-1:0]   w_bcd;
  logic [VALUE_W-1:0] w_clamped;
  logic [VALUE_W-1:0] w_start_val;

  logic [VALUE_W-1:0] r_shadow;
  logic               r_shadow_vld;
  logic [BCD_W-1:0]   r_pending;
  logic               r_ready;
  logic [BCD_W-1:0]   r_display;
  logic               r_overflow;

  assign w_clamped   = clamp_value(bus.value);
  // A fresh load in DONE supersedes any shadowed value.
  assign w_start     = bus.load ? (!w_busy || w_done) : (w_done && r_shadow_vld);
  assign w_start_val = bus.load ? w_clamped : r_shadow;

  bin2bcd_serial #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk    (clk),
    .resetN (resetN),
    .start  (w_start),
    .value  (w_start_val),
    .busy   (w_busy),
    .done   (w_done),
    .bcd    (w_bcd)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_pending    <= '0;
      r_ready      <= 1'b0;
      r_display    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (bus.load) r_overflow <= (bus.value > MAX_VAL);

      if (bus.load && w_busy && !w_done) begin
        r_shadow     <= w_clamped;
        r_shadow_vld <= 1'b1;
      end else if (w_done) begin
        r_shadow_vld <= 1'b0;
      end

      // A result landing on the frame pulse waits for the following frame.
      if (bus.startOfFrame && r_ready) r_display <= r_pending;
      if (w_done) begin
        r_pending <= w_bcd;
        r_ready   <= 1'b1;
      end else if (bus.startOfFrame && r_ready) begin
        r_ready <= 1'b0;
      end
    end
  end

  logic signed [11:0] w_relx;
  logic signed [11:0] w_rely;
  logic               w_in_row;
  logic [IDX_W-1:0]   w_idx;
  bcd_t               w_sel;
  logic               w_blank;
  logic               w_lead;
  logic               w_show;

  assign w_relx   = $signed({1'b0, bus.pixelX}) - ORG_X;
  assign w_rely   = $signed({1'b0, bus.pixelY}) - ORG_Y;
  assign w_in_row = !w_relx[11] && (w_relx < ROW_W) && !w_rely[11] && (w_rely < ROW_H);
  assign w_idx    = w_relx[LOG_W +: IDX_W];

  always_comb begin
    w_sel   = '0;
    w_blank = 1'b0;
    w_lead  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(w_idx)) begin
        w_sel   = r_display[(NUM_DIGITS-1-i)*4 +: 4];
        w_blank = (BLANK_LEADING != 0) && (i != NUM_DIGITS - 1) && w_lead &&
                  (r_display[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
      end
      w_lead = w_lead && (r_display[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
    end
  end

  assign w_show = w_in_row && !w_blank;

  bcd_t               r_digit_p1;
  logic [PIXEL_W-1:0] r_offx_p1;
  logic [PIXEL_W-1:0] r_offy_p1;
  logic               r_inside_p1;

  // Stage p1: registered glyph request
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_digit_p1  <= '0;
      r_offx_p1   <= '0;
      r_offy_p1   <= '0;
      r_inside_p1 <= 1'b0;
    end else begin
      r_inside_p1 <= w_show;
      r_digit_p1  <= w_show ? w_sel : 4'd0;
      r_offx_p1   <= w_show ? PIXEL_W'(w_relx[LOG_W-1:0]) : '0;
      r_offy_p1   <= w_show ? w_rely[PIXEL_W-1:0] : '0;
    end
  end

  assign bus.digit           = r_digit_p1;
  assign bus.offsetX         = r_offx_p1;
  assign bus.offsetY         = r_offy_p1;
  assign bus.insideRectangle = r_inside_p1;
  assign bus.busy            = w_busy;
  assign bus.overflow        = r_overflow;

endmodule

// File: tb/tb_score_digit_driver.sv
// Scoreboarded bench for score_digit_driver: random values and pixels against a decimal model.
module tb_score_digit_driver;
  import gamestats_pkg::*;

  localparam int TLX = 8;
  localparam int TLY = 4;
  localparam int VW  = 14;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  score_digit_driver_if #(.VALUE_W(VW)) bus();

  score_digit_driver #(
    .NUM_DIGITS    (4),
    .VALUE_W       (VW),
    .DIGIT_W       (16),
    .DIGIT_H       (32),
    .TOP_LEFT_X    (TLX),
    .TOP_LEFT_Y    (TLY),
    .BLANK_LEADING (1)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    int          px;
    int          py;
    logic [26:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_disp = 0;
  int   pend_val = 0;
  int   last_acc = 0;
  bit   pend_rdy = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: decimal digits by division, blanking from the value's magnitude.
  function automatic logic [26:0] ref_pixel(input int px, input int py, input int dv);
    int rx;
    int ry;
    int idx;
    int p10;
    logic [26:0] r;
    rx = px - TLX;
    ry = py - TLY;
    r  = '0;
    if (rx >= 0 && rx < 64 && ry >= 0 && ry < 32) begin
      idx = rx / 16;
      p10 = 10 ** (3 - idx);
      if (!(idx < 3 && dv < p10))
        r = {1'b1, 4'((dv / p10) % 10), 11'(rx % 16), 11'(ry)};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [26:0] act;
      e   = sb_q.pop_front();
      act = {bus.insideRectangle, bus.digit, bus.offsetX, bus.offsetY};
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL pixel(%0d,%0d): got ins=%0d dig=%0d ox=%0d oy=%0d, expected ins=%0d dig=%0d ox=%0d oy=%0d",
                 e.px, e.py, act[26], act[25:22], act[21:11], act[10:0],
                 e.exp[26], e.exp[25:22], e.exp[21:11], e.exp[10:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    bus.value = VW'(v);
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    last_acc  = (v > 9999) ? 9999 : v;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      tick();
      k++;
    end
    chk("idle_reached", bus.busy, 0);
    pend_val = last_acc;
    pend_rdy = 1'b1;
  endtask

  task automatic sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    if (pend_rdy) begin
      model_disp = pend_val;
      pend_rdy   = 1'b0;
    end
  endtask

  task automatic pix(input int x, input int y);
    exp_t e;
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    @(posedge clk);
    e.px  = x;
    e.py  = y;
    e.exp = ref_pixel(x, y, model_disp);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic scan_rand(input int n);
    for (int i = 0; i < n; i++) pix($urandom_range(0, 80), $urandom_range(0, 42));
  endtask

  task automatic scan_cells();
    for (int c = 0; c < 4; c++) pix(TLX + 16*c + $urandom_range(0, 15), TLY + $urandom_range(0, 31));
  endtask

  task automatic drain();
    repeat (2) tick();
  endtask

  initial begin
    int v;
    int drop;
    bus.value        = '0;
    bus.load         = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.pixelX       = '0;
    bus.pixelY       = '0;

    repeat (3) tick();
    chk("rst_digit",    bus.digit, 0);
    chk("rst_offsetX",  bus.offsetX, 0);
    chk("rst_offsetY",  bus.offsetY, 0);
    chk("rst_inside",   bus.insideRectangle, 0);
    chk("rst_busy",     bus.busy, 0);
    chk("rst_overflow", bus.overflow, 0);
    resetN = 1'b1;
    tick();

    do_load(1234);
    chk("busy_T1_1234", bus.busy, 1);
    chk("ovf_1234", bus.overflow, 0);
    repeat (14) tick();
    chk("busy_done_cycle", bus.busy, 1);
    tick();
    chk("busy_after_done", bus.busy, 0);
    wait_idle();
    sof();
    pix(TLX + 16, TLY + 5);
    pix(TLX + 63, TLY);
    pix(TLX + 64, TLY);
    pix(TLX - 1,  TLY);
    pix(TLX,      TLY - 1);
    pix(TLX,      TLY + 31);
    pix(TLX,      TLY + 32);
    scan_rand(20);
    drain();

    do_load(7);
    wait_idle();
    sof();
    scan_cells();
    scan_cells();
    drain();

    do_load(16383);
    chk("ovf_16383", bus.overflow, 1);
    wait_idle();
    sof();
    scan_cells();
    drain();

    do_load(5);
    tick();
    do_load(42);
    drop = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (!bus.busy) drop++;
    end
    chk("shadow_busy_gaps", drop, 0);
    tick();
    chk("shadow_busy_end", bus.busy, 0);
    chk("ovf_42", bus.overflow, 0);
    wait_idle();
    sof();
    scan_cells();
    scan_rand(8);
    drain();

    for (int it = 0; it < 6; it++) begin
      v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 16383);
      do_load(v);
      chk("ovf_rand", bus.overflow, (v > 9999) ? 1 : 0);
      wait_idle();
      sof();
      scan_cells();
      scan_rand(12);
      drain();
    end

    do_load(9876);
    wait_idle();
    sof();
    scan_cells();
    drain();
    do_load(15000);
    repeat (5) tick();
    resetN = 1'b0;
    #1;
    chk("arst_busy",     bus.busy, 0);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_digit",    bus.digit, 0);
    chk("arst_offsetX",  bus.offsetX, 0);
    chk("arst_offsetY",  bus.offsetY, 0);
    chk("arst_inside",   bus.insideRectangle, 0);
    tick();
    resetN     = 1'b1;
    model_disp = 0;
    pend_rdy   = 1'b0;
    repeat (20) tick();
    chk("aborted_busy", bus.busy, 0);
    sof();
    scan_cells();
    scan_rand(10);
    drain();

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_digit_driver.md
# score_digit_driver

Converts a binary game value (score, lives, timer) into decimal digits and, for every scanned pixel, drives the digit select and pixel offsets into the number glyph renderer. The glyph renderer is a digit bitmap: it takes a digit code plus X/Y offsets and returns a drawing request. This block computes the BCD digits and the per-pixel addressing, and keeps the displayed value tear-free across a frame. It sits between game logic and the glyph renderer in the GameStats display path.

## Interface
- NUM_DIGITS, 4, number of displayed decimal digits
- VALUE_W, 14, width of binary input value
- DIGIT_W, 16, glyph width in pixels (power of 2)
- DIGIT_H, 32, glyph height in pixels (power of 2)
- TOP_LEFT_X, 0, X of leftmost digit's top-left corner
- TOP_LEFT_Y, 0, Y of the digit row's top edge
- BLANK_LEADING, 1, 1 = suppress leading zeros

Ports:
- clk  in  1  clock
- resetN  in  1  reset: resetN, asynchronous, active-low; clock clk
- value  in  VALUE_W  binary value to display
- load  in  1  single-cycle request to convert value
- startOfFrame  in  1  one-cycle pulse at frame start
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- digit  out  4  BCD code of the digit under the pixel
- offsetX  out  11  pixel X offset inside the current glyph, 0..DIGIT_W-1
- offsetY  out  11  pixel Y offset inside the current glyph, 0..DIGIT_H-1
- insideRectangle  out  1  pixel lies inside a shown glyph cell
- busy  out  1  conversion in progress
- overflow  out  1  last accepted value was saturated

## Operation
- Clamp on accept: if value > 10^NUM_DIGITS-1, the accepted value is 10^NUM_DIGITS-1 and overflow is set. Otherwise overflow is cleared.
- Conversion: serial double-dabble, one shift per cycle, VALUE_W iterations. The add-3 correction is applied on every BCD nibble that is ≥5 before each shift.
- States:
  - IDLE: load → CONVERT (latch the clamped value, reset the iteration count).
  - CONVERT: after VALUE_W shifts → DONE.
  - DONE, one cycle: result is written to the pending register, the ready flag is set. Then → CONVERT if the shadow flag is set, else → IDLE.
- Load while busy: value is captured in a one-entry shadow register, last write wins, and the shadow flag is set. The shadow conversion starts right after DONE. Earlier shadow values are dropped.
- Display commit: on startOfFrame with the ready flag set, the pending register copies to the display register and ready clears.
  - If DONE and startOfFrame occur in the same cycle, the new result commits at the next frame.
- Pixel mapping: relX = pixelX-TOP_LEFT_X and relY = pixelY-TOP_LEFT_Y, computed in 12-bit signed arithmetic.
  - Inside when 0 ≤ relX < NUM_DIGITS*DIGIT_W and 0 ≤ relY < DIGIT_H.
  - Digit index = relX >> log2(DIGIT_W); index 0 is the most significant digit.
  - offsetX = relX mod DIGIT_W, offsetY = relY.
- Blanking (BLANK_LEADING=1): zero digits to the left of the first nonzero digit force insideRectangle=0. The least significant digit is never blanked.
- Outside any shown cell: insideRectangle=0, digit=0, offsets=0.

## Timing
- Reset values:
  - Outputs: digit 0, offsetX 0, offsetY 0, insideRectangle 0, busy 0, overflow 0.
  - Internal: display, pending and shadow registers 0; ready and shadow flags 0; FSM IDLE.
- Pixel path: one registered stage. Outputs reflect pixelX/pixelY sampled one cycle earlier, so the drawing request arrives 2 cycles after the pixel coordinates.
- Conversion timeline, with load sampled at cycle T in IDLE:
  - busy=1 from T+1 through T+VALUE_W+1 (DONE).
  - busy=0 at T+VALUE_W+2 if there is no shadow request.
- overflow updates at T+1.
- Reset mid-conversion aborts the conversion. The display shows 0 after reset.

## Structure
- Package gamestats_pkg:
  - bcd_t (logic[3:0])
  - DIGIT_W_DEF, DIGIT_H_DEF, PIXEL_W=11
- Sub-module bin2bcd_serial holds the FSM, iteration counter and double-dabble datapath. Handshake: start, value in; busy, done, bcd out.
- The top level holds the shadow, pending and display registers and the pixel mapper.

## Test plan
- Load 1234, wait 16 cycles, pulse startOfFrame. Pixel (TOP_LEFT_X+16, TOP_LEFT_Y+5) → next cycle digit=2, offsetX=0, offsetY=5, insideRectangle=1.
- Load 7 with BLANK_LEADING=1 → pixels in digit cells 0..2 give insideRectangle=0; cell 3 gives digit=7, insideRectangle=1.
- Load 16383 → overflow=1 at T+1; after commit all cells show 9.
- Load 5, then load 42 two cycles later → busy stays high through the second conversion; after startOfFrame the display shows 42, and 5 is never committed.
- Assert resetN low at cycle T+6 of a conversion → busy=0 and the outputs hold reset values. Every cell shows 0 and only cell 3 is inside.
- Pixel X = TOP_LEFT_X+63 → inside, digit cell 3, offsetX=15. X = TOP_LEFT_X+64 or TOP_LEFT_X-1 → insideRectangle=0.
